// File: rtl/mem_req_queue.sv
// -----------------------------------------------------------------------------
// mem_req_queue
//
// Request front end for the DDR5 command state machine (MemCont). Host read and
// write requests are buffered in a circular FIFO. The head entry is presented
// to the controller as rd_valid / wr_valid with its row and column. The head is
// popped whenever the controller signals ready.
//
// ppl is a page-hit pipelining hint. It is high when the entry behind the head
// targets the same row in the same direction. The controller can then stay in
// RD/WR instead of auto-precharging.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   flush       in   synchronous queue clear (discards same-cycle push/pop)
//   req_valid   in   host request strobe
//   req_ready   out  queue can accept (== !full)
//   req_wr      in   1 = write, 0 = read
//   req_row     in   request row [ROW_W]
//   req_col     in   request column [COL_W]
//   cont_ready  in   controller ready; pops the head when it is valid
//   rd_valid    out  head entry is a read
//   wr_valid    out  head entry is a write
//   ppl         out  next entry has same row and direction as head
//   cmd_row     out  head row (0 when empty)
//   cmd_col     out  head column (0 when empty)
//   count       out  number of entries held [$clog2(DEPTH)+1]
//   ovf_err     out  sticky: push attempted while full (cleared by reset only)
// -----------------------------------------------------------------------------
module mem_req_queue #(
    parameter int DEPTH = 8,
    parameter int ROW_W = 16,
    parameter int COL_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [ROW_W-1:0]           req_row,
    input  logic [COL_W-1:0]           req_col,
    input  logic                       cont_ready,
    output logic                       rd_valid,
    output logic                       wr_valid,
    output logic                       ppl,
    output logic [ROW_W-1:0]           cmd_row,
    output logic [COL_W-1:0]           cmd_col,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ROW_W + COL_W;

    // Entry layout: {wr, row, col}
    localparam int WR_BIT  = ENT_W - 1;
    localparam int ROW_MSB = ROW_W + COL_W - 1;
    localparam int ROW_LSB = COL_W;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] nxt_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;

    logic             head_wr;
    logic [ROW_W-1:0] head_row;
    logic [COL_W-1:0] head_col;
    logic             nxt_wr;
    logic [ROW_W-1:0] nxt_row;

    // ------------------------------------------------------------------
    // Queue status and handshakes
    // ------------------------------------------------------------------
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid & !full;
    // rd_valid | wr_valid reduces to !empty
    assign pop       = cont_ready & !empty;

    // Power-of-two depth lets the pointer wrap by plain overflow.
    assign nxt_ptr   = rd_ptr + PTR_W'(1);

    // ------------------------------------------------------------------
    // Entry storage: no reset, contents are only meaningful below count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {req_wr, req_row, req_col};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            // Same-cycle push/pop are dropped; the overflow record survives.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= nxt_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (req_valid && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head and look-ahead decode (combinational from registered state)
    // ------------------------------------------------------------------
    assign head_wr  = mem[rd_ptr][WR_BIT];
    assign head_row = mem[rd_ptr][ROW_MSB:ROW_LSB];
    assign head_col = mem[rd_ptr][COL_W-1:0];
    assign nxt_wr   = mem[nxt_ptr][WR_BIT];
    assign nxt_row  = mem[nxt_ptr][ROW_MSB:ROW_LSB];

    // Gating on empty keeps stale storage from leaking out, including while
    // reset holds count at zero.
    assign rd_valid = !empty && !head_wr;
    assign wr_valid = !empty &&  head_wr;
    assign cmd_row  = empty ? '0 : head_row;
    assign cmd_col  = empty ? '0 : head_col;

    // The look-ahead slot only holds a real request once two are queued.
    assign ppl = (count >= CNT_W'(2)) ? ((nxt_row == head_row) && (nxt_wr == head_wr))
                                      : 1'b0;

endmodule
